pc_fetch_sequencer: RTL and testbench

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

---
 rtl/pc_fetch_sequencer_pkg.sv | 32 +++
 rtl/pc_fetch_sequencer_if.sv | 16 +
 rtl/pc_fetch_buffer.sv | 47 ++++
 rtl/pc_fetch_sequencer.sv | 118 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer.
//   pc_action_e   : Pc_Action codes driven by the PC control logic
//   fetch_state_e : fetch FSM states
//   PC_STEP       : sequential address increment
//   align_word()  : clears the two byte-offset bits of an address
//   is_redirect() : true for actions that change control flow
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        PC_NONE   = 2'd0,
        PC_INC    = 2'd1,
        PC_JUMP   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_action_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request outstanding
        ST_WAIT  = 2'd1,   // buffer full and stalled, no request
        ST_KILL  = 2'd2    // draining a request made stale by a redirect
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic is_redirect(input pc_action_e a);
        return (a == PC_JUMP) || (a == PC_BRANCH);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory read bus.
//   imem_req  : read request (master -> slave)
//   imem_addr : word-aligned read address (master -> slave)
//   imem_ack  : read data valid this cycle (slave -> master)
//   imem_data : instruction word (slave -> master)
interface pc_fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_data);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_data);
endinterface

// File: rtl/pc_fetch_buffer.sv
// One-entry output buffer holding a fetched instruction and its address.
//   clk, i_rst_n : clock, synchronous active-low reset
//   i_load       : capture i_instr/i_pc and mark valid
//   i_drain      : consumer took the entry this cycle
//   i_invalidate : drop the entry (redirect); wins over load and drain
//   o_valid/o_instr/o_pc : buffered entry
module pc_fetch_buffer
    import pc_fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_invalidate,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // Load beats drain so a simultaneous drain+load keeps the buffer full.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_invalidate) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: issues word reads to instruction memory,
// buffers one instruction for decode, and handles jump/branch redirects.
//   clock, reset_n     : clock, synchronous active-low reset
//   action             : Pc_Action code, valid every cycle
//   jump_target        : redirect address for Jump
//   branch_target      : redirect address for Branch
//   stall              : decode cannot accept an instruction this cycle
//   imem               : instruction-memory bus (master side)
//   fetch_valid/instr/pc : buffered instruction presented to decode
//   flush              : a redirect is accepted this cycle
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [1:0]                  action,
    input  logic [31:0]                 jump_target,
    input  logic [31:0]                 branch_target,
    input  logic                        stall,
    pc_fetch_sequencer_if.master        imem,
    output logic                        fetch_valid,
    output logic [31:0]                 fetch_instr,
    output logic [31:0]                 fetch_pc,
    output logic                        flush
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;            // address currently requested
    logic [31:0]  r_kill_target;   // where to resume once the stale ack lands

    pc_action_e   w_action;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_buf_valid;
    logic         w_full_stall;
    logic         w_req;
    logic         w_ack;
    logic         w_load;
    logic         w_drain;

    assign w_action     = pc_action_e'(action);
    assign w_redirect   = reset_n && is_redirect(w_action);
    assign w_target     = align_word((w_action == PC_JUMP) ? jump_target : branch_target);
    assign w_full_stall = w_buf_valid && stall;

    // No new request while the buffer is full and decode is stalled.
    assign w_req   = reset_n && ((r_state == ST_KILL) ||
                                 ((r_state == ST_FETCH) && !w_full_stall));
    assign w_ack   = w_req && imem.imem_ack;
    assign w_load  = (r_state == ST_FETCH) && w_ack && !w_redirect;
    assign w_drain = w_buf_valid && !stall;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign flush          = w_redirect;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= align_word(RESET_PC);
            r_kill_target <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_redirect) begin
                        if (w_req && !imem.imem_ack) begin
                            r_state       <= ST_KILL;
                            r_kill_target <= w_target;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (w_full_stall) begin
                        r_state <= ST_WAIT;
                    end else if (w_ack) begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                ST_WAIT: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= ST_FETCH;
                    end else if (!stall) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_KILL: begin
                    // The stale ack completes the old request; resume at the
                    // newest target, including one arriving this very cycle.
                    if (imem.imem_ack) begin
                        r_pc    <= w_redirect ? w_target : r_kill_target;
                        r_state <= ST_FETCH;
                    end else if (w_redirect) begin
                        r_kill_target <= w_target;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    pc_fetch_buffer u_buf (
        .clk          (clock),
        .i_rst_n      (reset_n),
        .i_load       (w_load),
        .i_drain      (w_drain),
        .i_invalidate (w_redirect),
        .i_instr      (imem.imem_data),
        .i_pc         (r_pc),
        .o_valid      (w_buf_valid),
        .o_instr      (fetch_instr),
        .o_pc         (fetch_pc)
    );

    assign fetch_valid = w_buf_valid;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by random
// traffic, with a scoreboard that predicts the instruction stream decode
// should see (sequential from the last redirect target or RESET_PC).
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [1:0]  A_NONE = 2'd0;
    localparam logic [1:0]  A_JUMP = 2'd2;
    localparam logic [1:0]  A_BR   = 2'd3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  action = A_NONE;
    logic [31:0] jump_target = '0;
    logic [31:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        ack_en = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        flush;

    always #5 clock = ~clock;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    pc_fetch_sequencer_if bus ();
    assign bus.imem_ack  = bus.imem_req & ack_en;
    assign bus.imem_data = memfn(bus.imem_addr);

    pc_fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .action        (action),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .stall         (stall),
        .imem          (bus),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_pc      (fetch_pc),
        .flush         (flush)
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_consumed = 0;
    logic [31:0] redir_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, 32'(got), 32'(exp));
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic rn, input logic [1:0] act, input logic [31:0] j,
                         input logic [31:0] b, input logic st, input logic ae);
        @(posedge clock);
        #1;
        reset_n       = rn;
        action        = rn ? act : A_NONE;
        jump_target   = j;
        branch_target = b;
        stall         = st;
        ack_en        = ae;
        if (rn && act[1])
            redir_q.push_back(((act == A_JUMP) ? j : b) & 32'hFFFF_FFFC);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    logic        prev_rst = 1'b1;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc = RST_PC;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk1("rst_req", bus.imem_req, 1'b0);
            chk1("rst_flush", flush, 1'b0);
            exp_pc = RST_PC;
            redir_q.delete();
            prev_rst = 1'b1;
            prev_req = 1'b0;
        end else begin
            if (prev_rst) begin
                chk1("post_rst_valid", fetch_valid, 1'b0);
                chk("post_rst_pc", fetch_pc, 32'h0);
                chk("post_rst_instr", fetch_instr, 32'h0);
            end
            chk1("flush", flush, action[1]);
            if (bus.imem_req)
                chk("addr_align", 32'(bus.imem_addr[1:0]), 32'h0);
            if (prev_req && !prev_ack && bus.imem_req)
                chk("addr_hold", bus.imem_addr, prev_addr);
            if (action[1]) begin
                chk("redir_q_depth", 32'(redir_q.size()), 32'd1);
                if (redir_q.size() != 0)
                    exp_pc = redir_q.pop_front();
            end else if (fetch_valid && !stall) begin
                chk("sb_pc", fetch_pc, exp_pc);
                chk("sb_instr", fetch_instr, memfn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            prev_req  = bus.imem_req;
            prev_ack  = bus.imem_ack;
            prev_addr = bus.imem_addr;
            prev_rst  = 1'b0;
        end
    end

    initial begin
        int r;
        logic [1:0]  act;
        logic [31:0] tj, tb;

        repeat (3) drive(1'b0, A_NONE, '0, '0, 1'b0, 1'b1);

        // Zero-wait sequential fetch from reset.
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk1("A_req", bus.imem_req, 1'b1);
        chk("A_addr", bus.imem_addr, 32'h0);
        chk1("A_valid", fetch_valid, 1'b0);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk("B_addr", bus.imem_addr, 32'h4);
        chk1("B_valid", fetch_valid, 1'b1);
        chk("B_instr", fetch_instr, memfn(32'h0));
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk("C_addr", bus.imem_addr, 32'h8);
        chk("C_fpc", fetch_pc, 32'h4);

        // Stall three cycles with the instruction at 8 buffered.
        drive(1'b1, A_NONE, '0, '0, 1'b1, 1'b1); #3;
        chk("D_addr", bus.imem_addr, 32'hC);
        chk1("D_req", bus.imem_req, 1'b0);
        chk("D_fpc", fetch_pc, 32'h8);
        repeat (2) begin
            drive(1'b1, A_NONE, '0, '0, 1'b1, 1'b1); #3;
            chk1("W_req", bus.imem_req, 1'b0);
            chk("W_fpc", fetch_pc, 32'h8);
            chk1("W_valid", fetch_valid, 1'b1);
        end
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk1("G_req", bus.imem_req, 1'b0);
        chk("G_fpc", fetch_pc, 32'h8);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk1("H_req", bus.imem_req, 1'b1);
        chk("H_addr", bus.imem_addr, 32'hC);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b0); #3;
        chk("I_addr", bus.imem_addr, 32'h10);
        chk("I_fpc", fetch_pc, 32'hC);

        // Jump in the same cycle as the ack of 0x10.
        drive(1'b1, A_JUMP, 32'h100, '0, 1'b0, 1'b1); #3;
        chk1("J_flush", flush, 1'b1);
        chk("J_addr", bus.imem_addr, 32'h10);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b0); #3;
        chk("K_addr", bus.imem_addr, 32'h100);
        chk1("K_valid", fetch_valid, 1'b0);
        chk1("K_flush", flush, 1'b0);

        // Branch with a delayed ack, then a second jump while killing.
        drive(1'b1, A_BR, '0, 32'h203, 1'b0, 1'b0); #3;
        chk1("L_flush", flush, 1'b1);
        repeat (2) begin
            drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b0); #3;
            chk1("KILL_req", bus.imem_req, 1'b1);
            chk("KILL_addr", bus.imem_addr, 32'h100);
        end
        drive(1'b1, A_JUMP, 32'h300, '0, 1'b0, 1'b0); #3;
        chk("O_addr", bus.imem_addr, 32'h100);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk("P_addr", bus.imem_addr, 32'h100);
        chk1("P_valid", fetch_valid, 1'b0);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk("Q_addr", bus.imem_addr, 32'h300);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b0); #3;
        chk("R_fpc", fetch_pc, 32'h300);
        chk("R_addr", bus.imem_addr, 32'h304);

        // Address wrap at the top of memory.
        drive(1'b1, A_JUMP, 32'hFFFF_FFFC, '0, 1'b0, 1'b1); #3;
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk("T_addr", bus.imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b0); #3;
        chk("U_addr", bus.imem_addr, 32'h0);
        chk("U_fpc", fetch_pc, 32'hFFFF_FFFC);

        // Random traffic.
        n_consumed = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 15);
            act = (r == 0) ? A_JUMP : (r == 1) ? A_BR : 2'($urandom_range(0, 1));
            tj = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            tb = $urandom;
            drive(($urandom_range(0, 299) != 0), act, tj, tb,
                  ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end
        drive(1'b1, A_NONE, '0, '0, 1'b0, 1'b1); #3;
        chk1("progress", (n_consumed > 200), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
